// File: rtl/fifo_control_if.sv
// Handshake and status bundle between the FIFO pointer/flag controller and its users.
// The controller takes the slave modport; the producer/consumer side takes the master modport.
interface fifo_control_if #(
   parameter int PTR_WIDTH = 3
);
   logic                 push;
   logic                 pop;
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic                 write_enable;
   logic                 read_enable;
   logic [PTR_WIDTH:0]   fifo_count;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic                 error;

   // Handshake: push/pop are single-cycle requests. A request is accepted in the
   // cycle it is presented exactly when the matching enable is high in that cycle;
   // a rejected request is dropped, never held or retried by the controller.
   modport master (
      output push, pop,
      input  wr_ptr, rd_ptr, write_enable, read_enable, fifo_count,
      input  full, empty, almost_full, almost_empty, error
   );

   modport slave (
      input  push, pop,
      output wr_ptr, rd_ptr, write_enable, read_enable, fifo_count,
      output full, empty, almost_full, almost_empty, error
   );
endinterface

// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for an 8-entry synchronous FIFO memory.
// Define FIFO_ERR_DETECT_EN to enable the sticky illegal-access error flag.
module fifo_control #(
   parameter int DEPTH     = 8,
   parameter int PTR_WIDTH = 3,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 2
) (
   input logic           clk,
   input logic           reset,
   fifo_control_if.slave bus
);
   localparam logic [PTR_WIDTH:0] COUNT_FULL = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0] COUNT_AF   = (PTR_WIDTH+1)'(AF_THRESH);
   localparam logic [PTR_WIDTH:0] COUNT_AE   = (PTR_WIDTH+1)'(AE_THRESH);

   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [PTR_WIDTH:0]   count;
   logic                 full;
   logic                 empty;
   logic                 push_ok;
   logic                 pop_ok;

   assign full  = (count == COUNT_FULL);
   assign empty = (count == '0);

   // A push into a full FIFO is legal only while the same cycle frees a slot.
   assign pop_ok  = bus.pop & ~empty;
   assign push_ok = bus.push & (~full | pop_ok);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_ERR_DETECT_EN
   logic error_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         error_r <= 1'b0;
      end else if ((bus.push & ~push_ok) | (bus.pop & ~pop_ok)) begin
         error_r <= 1'b1;
      end
   end

   assign bus.error = error_r;
`else
   assign bus.error = 1'b0;
`endif

   assign bus.wr_ptr       = wr_ptr;
   assign bus.rd_ptr       = rd_ptr;
   assign bus.fifo_count   = count;
   assign bus.write_enable = push_ok & ~reset;
   assign bus.read_enable  = pop_ok & ~reset;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= COUNT_AF);
   assign bus.almost_empty = (count <= COUNT_AE);
endmodule

// File: tb/tb_fifo_control.sv
// Self-checking bench for fifo_control: directed steps plus random push/pop/reset,
// compared against a queue-based reference model and a small behavioural memory.
module tb_fifo_control;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [11:0] din = '0;
   logic [11:0] data_out;
   logic [11:0] mem [8];

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [11:0] exp_q[$];
   int          wp_m = 0;
   int          rp_m = 0;
   logic        err_m = 1'b0;

   fifo_control_if #(.PTR_WIDTH(3)) bus ();

   fifo_control #(
      .DEPTH(8), .PTR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // FIFO memory: write on write_enable, registered read returning the old entry
   always @(posedge clk) begin
      if (bus.write_enable) mem[bus.wr_ptr] <= din;
      if (bus.read_enable)  data_out <= mem[bus.rd_ptr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic p, input logic q, input logic r, input logic [11:0] d);
      bit          pop_ok;
      bit          push_ok;
      int          sz;
      logic [11:0] exp_data;
      @(negedge clk);
      bus.push = p;
      bus.pop  = q;
      reset    = r;
      din      = d;
      sz       = exp_q.size();
      pop_ok   = q && (sz > 0);
      push_ok  = p && ((sz < 8) || pop_ok);
      exp_data = '0;
      #1;
      check("write_enable", 32'(bus.write_enable), 32'(push_ok && !r));
      check("read_enable",  32'(bus.read_enable),  32'(pop_ok && !r));
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         wp_m  = 0;
         rp_m  = 0;
         err_m = 1'b0;
      end else begin
         if (pop_ok) begin
            exp_data = exp_q.pop_front();
            rp_m = (rp_m + 1) % 8;
         end
         if (push_ok) begin
            exp_q.push_back(d);
            wp_m = (wp_m + 1) % 8;
         end
`ifdef FIFO_ERR_DETECT_EN
         if ((p && !push_ok) || (q && !pop_ok)) err_m = 1'b1;
`endif
         if (pop_ok) check("data_out", 32'(data_out), 32'(exp_data));
      end
      sz = exp_q.size();
      check("fifo_count",   32'(bus.fifo_count),   32'(sz));
      check("wr_ptr",       32'(bus.wr_ptr),       32'(wp_m));
      check("rd_ptr",       32'(bus.rd_ptr),       32'(rp_m));
      check("full",         32'(bus.full),         32'(sz == 8));
      check("empty",        32'(bus.empty),        32'(sz == 0));
      check("almost_full",  32'(bus.almost_full),  32'(sz >= 6));
      check("almost_empty", 32'(bus.almost_empty), 32'(sz <= 2));
      check("error",        32'(bus.error),        32'(err_m));
   endtask

   initial begin
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      // reset and idle
      step(1'b0, 1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b0, 1'b0, 12'h000);
      // fill with 0x001..0x008; wr_ptr wraps to 0
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 12'(i));
      // full: simultaneous push and pop
      step(1'b1, 1'b1, 1'b0, 12'h0a5);
      // full: push alone is rejected
      step(1'b1, 1'b0, 1'b0, 12'h0ee);
      step(1'b0, 1'b0, 1'b0, 12'h000);
      // drain
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 12'h000);
      // empty: push and pop together, then pop to empty, then pop while empty
      step(1'b1, 1'b1, 1'b0, 12'h123);
      step(1'b0, 1'b1, 1'b0, 12'h000);
      step(1'b0, 1'b1, 1'b0, 12'h000);
      // reset mid-burst after 5 pushes
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 12'(12'h200 + i));
      step(1'b1, 1'b1, 1'b1, 12'h2ff);
      step(1'b1, 1'b0, 1'b0, 12'h3c3);
      step(1'b0, 1'b1, 1'b0, 12'h000);
      // random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 40) == 0), 12'($urandom_range(0, 4095)));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_control.md
# fifo_control

Pointer and flag controller for the transaction-layer FIFO. It accepts push/pop requests from the producer and consumer. It drives the write/read pointers and enables of the 8-entry synchronous FIFO memory, whose read data is registered one cycle after `read_enable`. It keeps the occupancy count and publishes full/empty, almost-full/almost-empty and error status to the transaction layer.

## Interface
- `DEPTH`, 8, number of memory entries; must equal 2^`PTR_WIDTH`
- `PTR_WIDTH`, 3, pointer width; matches the memory address ports
- `AF_THRESH`, 6, `almost_full` asserts when count >= this value
- `AE_THRESH`, 2, `almost_empty` asserts when count <= this value

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `push`  in  1  producer write request; data is presented to memory in the same cycle
- `pop`  in  1  consumer read request
- `wr_ptr`  out  PTR_WIDTH  memory write address (registered)
- `rd_ptr`  out  PTR_WIDTH  memory read address (registered)
- `write_enable`  out  1  memory write strobe (combinational from accepted push)
- `read_enable`  out  1  memory read strobe (combinational from accepted pop)
- `fifo_count`  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count >= AF_THRESH
- `almost_empty`  out  1  count <= AE_THRESH
- `error`  out  1  sticky illegal-access flag (see Configuration)

## Operation
- Registered state: `wr_ptr`, `rd_ptr`, `count`, `error`. All flags are combinational decodes of `count`.
- `pop_ok = pop & !empty`.
- `push_ok = push & (!full | pop_ok)`. A push when full is accepted only alongside an accepted pop. The memory then writes and reads the same address in that cycle; the read returns the old entry.
- `write_enable = push_ok & !reset`. `read_enable = pop_ok & !reset`.
- On `push_ok`: `wr_ptr <= wr_ptr + 1`, wrapping modulo DEPTH (7 -> 0).
- On `pop_ok`: `rd_ptr <= rd_ptr + 1`, wrapping modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged when both are accepted or neither is.
- Push with pop when empty: the push is accepted, the pop is rejected, and count becomes 1.
- Rejected requests change no state except `error` (when enabled).
- Reset at any time, including mid-burst, takes priority over push and pop:
  - pointers and count return to 0
  - memory contents are not cleared; they are simply unreachable
  - the enables are forced to 0 during reset.

## Timing
- Reset values:
  - `wr_ptr` = 0, `rd_ptr` = 0, `fifo_count` = 0
  - `empty` = 1, `almost_empty` = 1
  - `full` = 0, `almost_full` = 0
  - `error` = 0, `write_enable` = 0, `read_enable` = 0
- Pointer, count and flag changes are visible the cycle after the accepted request.
- Read latency: pop accepted in cycle N -> `FIFO_data_out` valid in cycle N+1.
- Write-to-read: a push in cycle N can be popped from cycle N+1, because `empty` has deasserted by then.
- There is no combinational path from `push`/`pop` to any flag.

## Configuration
- `FIFO_ERR_DETECT_EN` defined:
  - `error` is set (sticky) on a rejected push (full, no accepted pop) or a pop while empty.
  - It clears only on `reset`.
- Undefined:
  - `error` is tied to 0.
  - Illegal requests are still silently dropped, with identical pointer and count behaviour.

## Test plan
- Reset, then idle -> `empty`=1, `almost_empty`=1, `full`=0, pointers 0, count 0, both enables 0.
- 8 pushes of 0x001..0x008 -> count 8, `full`=1, `almost_full` from count 6, `wr_ptr` wrapped to 0. Then 8 pops -> data 0x001..0x008 each one cycle after its pop, `empty`=1.
- Full FIFO, push and pop in the same cycle -> both enables 1, count stays 8, both pointers advance by 1, the popped data is the oldest entry.
- Empty FIFO, push and pop in the same cycle -> `read_enable`=0, `write_enable`=1, count 1.
- With `FIFO_ERR_DETECT_EN`: a 9th push when full -> no write, count 8, `error`=1 and held until `reset`. Without the macro: same pointers and count, `error`=0.
- Reset asserted after 5 pushes -> next cycle count 0, pointers 0, `empty`=1. A following push/pop returns the newly pushed value.
